// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
`timescale 1ns/1ps
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int BIN_W_DEF  = 14;
    localparam int DIGITS_DEF = 4;
    localparam int BCD_W      = DIGITS_DEF * 4;

    function automatic int bcd_w(input int digits);
        return digits * 4;
    endfunction

    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
`timescale 1ns/1ps
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // 4-bit wrap is intentional; a valid digit plus 3 never exceeds 12
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready input.
// Define BCD_OVF_SAT_EN to saturate the digits to all nines on overflow.
`timescale 1ns/1ps
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0,
    output logic             out_valid,
    output logic             ovf
);

    localparam int               ACC_W   = bcd_w(DIGITS);
    localparam int               CW      = cnt_w(BIN_W);
    localparam longint unsigned  OVF_LIM = pow10(DIGITS);

    state_e                   state_q, state_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [ACC_W-1:0]         bcd_q, bcd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     ovfc_q, ovfc_d;
    logic [ACC_W-1:0]         dig_q, dig_d;
    logic                     ovf_q, ovf_d;
    logic                     vld_q, vld_d;

    logic [ACC_W-1:0]         bcd_adj;
    logic [ACC_W+BIN_W-1:0]   shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (bcd_q[g*4 +: 4]),
            .d_o (bcd_adj[g*4 +: 4])
        );
    end

    // Top accumulator bit falls off here, which yields the modulo result
    assign shifted = {bcd_adj, bin_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovfc_q  <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovfc_q  <= ovfc_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovfc_d   = ovfc_q;
        dig_d    = dig_q;
        ovf_d    = ovf_q;
        vld_d    = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = CW'(BIN_W);
                    ovfc_d  = (64'(bin_in) >= OVF_LIM);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[ACC_W+BIN_W-1:BIN_W];
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef BCD_OVF_SAT_EN
                dig_d = ovfc_q ? {DIGITS{4'h9}} : bcd_q;
`else
                dig_d = bcd_q;
`endif
                ovf_d   = ovfc_q;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // out_valid is registered so it rises on the same edge as the digits
    assign dig3      = dig_q[15:12];
    assign dig2      = dig_q[11:8];
    assign dig1      = dig_q[7:4];
    assign dig0      = dig_q[3:0];
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against an arithmetic decimal model.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
`ifdef BCD_OVF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [BIN_W-1:0] bin_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       dig3, dig2, dig1, dig0;
    logic             out_valid;
    logic             ovf;
    logic [15:0]      dig_all;

    int checks = 0;
    int errors = 0;

    assign dig_all = {dig3, dig2, dig1, dig0};

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dig3      (dig3),
        .dig2      (dig2),
        .dig1      (dig1),
        .dig0      (dig0),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    function automatic logic [15:0] exp_dig(input int v);
        int m;
        if (SAT && v >= 10000) return 16'h9999;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic exp_ovf(input int v);
        return v >= 10000;
    endfunction

    // Presents v and returns right at the accepting clock edge
    task automatic accept(input int v);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bin_in   = BIN_W'(v);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: value %0d never accepted (in_ready stayed %b, expected 1)", v, in_ready);
        end
    endtask

    // Counts clock edges from the accept edge until out_valid is seen; -1 on timeout
    task automatic wait_out(output int n, input bit keep, input int nextv);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (i == 0) begin
                if (keep) bin_in = BIN_W'(nextv);
                else in_valid = 1'b0;
            end
            if (out_valid) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++; if (dig_all !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", dig_all); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_zero();
        int n;
        accept(0);
        wait_out(n, 1'b0, 0);
        checks++; if (n !== 15) begin errors++; $display("FAIL zero_latency: got %0d want 15", n); end
        checks++; if (dig_all !== 16'h0000) begin errors++; $display("FAIL zero_digits: got %h want 0000", dig_all); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b want 0", ovf); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_1234();
        logic [15:0] prev;
        prev = dig_all;
        accept(1234);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready c%0d: got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_out_valid c%0d: got %b want 0", k, out_valid); end
            checks++; if (dig_all !== prev) begin errors++; $display("FAIL digits_stable c%0d: got %h want %h", k, dig_all, prev); end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL v1234_out_valid: got %b want 1", out_valid); end
        checks++; if (dig_all !== 16'h1234) begin errors++; $display("FAIL v1234_digits: got %h want 1234", dig_all); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL v1234_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL v1234_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        accept(9999);
        wait_out(n, 1'b1, 10000);
        checks++; if (n !== 15) begin errors++; $display("FAIL b2b_first_latency: got %0d want 15", n); end
        checks++; if (dig_all !== exp_dig(9999)) begin errors++; $display("FAIL b2b_first_digits: got %h want %h", dig_all, exp_dig(9999)); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_first_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b want 1", in_ready); end
        m = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (out_valid) begin m = i; break; end
        end
        checks++; if (m !== 16) begin errors++; $display("FAIL b2b_second_spacing: got %0d want 16", m); end
        checks++; if (dig_all !== exp_dig(10000)) begin errors++; $display("FAIL b2b_second_digits: got %h want %h", dig_all, exp_dig(10000)); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_second_ovf: got %b want 1", ovf); end
    endtask

    task automatic test_overflow();
        int n;
        accept(12345);
        wait_out(n, 1'b0, 0);
        checks++; if (n !== 15) begin errors++; $display("FAIL ovf_latency: got %0d want 15", n); end
        checks++; if (dig_all !== exp_dig(12345)) begin errors++; $display("FAIL ovf_digits: got %h want %h", dig_all, exp_dig(12345)); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    endtask

    task automatic test_busy_ignore();
        int k_done;
        int extra;
        k_done = -1;
        accept(4321);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k == 5) begin bin_in = BIN_W'(5678); in_valid = 1'b1; end
            if (k == 6) in_valid = 1'b0;
            if (out_valid) begin k_done = k; break; end
            @(posedge clk);
        end
        checks++; if (k_done !== 16) begin errors++; $display("FAIL busy_latency: got %0d want 16", k_done); end
        checks++; if (dig_all !== 16'h4321) begin errors++; $display("FAIL busy_digits: got %h want 4321", dig_all); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b want 1", in_ready); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra_result: got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        accept(8765);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (dig_all !== 16'h0000) begin errors++; $display("FAIL midrst_digits: got %h want 0000", dig_all); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_result: got %0d pulses want 0", pulses); end
        accept(42);
        wait_out(n, 1'b0, 0);
        checks++; if (n !== 15) begin errors++; $display("FAIL after_rst_latency: got %0d want 15", n); end
        checks++; if (dig_all !== 16'h0042) begin errors++; $display("FAIL after_rst_digits: got %h want 0042", dig_all); end
    endtask

    task automatic test_random();
        int n;
        int v;
        for (int t = 0; t < 25; t++) begin
            v = int'($urandom_range(0, (1 << BIN_W) - 1));
            accept(v);
            wait_out(n, 1'b0, 0);
            checks++; if (n !== 15) begin errors++; $display("FAIL rand_latency v=%0d: got %0d want 15", v, n); end
            checks++; if (dig_all !== exp_dig(v)) begin errors++; $display("FAIL rand_digits v=%0d: got %h want %h", v, dig_all, exp_dig(v)); end
            checks++; if (ovf !== exp_ovf(v)) begin errors++; $display("FAIL rand_ovf v=%0d: got %b want %b", v, ovf, exp_ovf(v)); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_1234();
        test_back_to_back();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative double-dabble converter: turns one unsigned binary value into DIGITS packed BCD nibbles.
- Sits directly upstream of the quad seven-segment driver; dig3..dig0 wire straight to its val3..val0 inputs.
- Valid/ready input handshake; registered digit outputs hold the last result between conversions.

Parameters:
- BIN_W, 14, width of the binary input; 14 covers 0..9999.
- DIGITS, 4, number of BCD digits produced; RTL must support DIGITS=4, and the display driver consumes four.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- bin_in  in  BIN_W  unsigned value to convert.
- in_valid  in  1  bin_in is presented.
- in_ready  out  1  converter idle; a transfer happens when in_valid && in_ready at a clk edge.
- dig3  out  4  thousands digit (BCD).
- dig2  out  4  hundreds digit.
- dig1  out  4  tens digit.
- dig0  out  4  units digit.
- out_valid  out  1  one-cycle pulse: dig3..dig0/ovf updated this cycle.
- ovf  out  1  last accepted value was >= 10^DIGITS; held with the digits.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - dig3..dig0=0; out_valid=0; ovf=0.
  - Shift register, BCD accumulator and counter cleared.
  - in_ready=1 while in reset and after release.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture bin_in into the shift register; clear the BCD accumulator (DIGITS*4 bits); count=BIN_W.
  - Compute the ovf candidate: bin_in >= 10^DIGITS.
  - Go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle, for every BCD digit >= 5, add 3 (4-bit, no carry out).
  - Then shift {bcd, bin} left by 1. Bits shifted out of the top digit are discarded.
  - Decrement count. After the cycle where count reaches 0 (exactly BIN_W SHIFT cycles), go to DONE.
- DONE:
  - in_ready=0. Register the accumulator into dig3..dig0 and ovf.
  - out_valid=1 for this single cycle; go to IDLE next cycle.
- Latency: accept edge to out_valid is BIN_W+1 cycles (15 at default).
- Throughput: one conversion per BIN_W+2 cycles.
- in_valid while busy: ignored, no queueing. Upstream must hold in_valid until in_ready.
- Back-to-back: in_valid held high is accepted on the IDLE cycle following DONE.
- Digit outputs change only in DONE; they are stable at all other times, including during SHIFT.
- Overflow, baseline (macro absent): digits = bin_in mod 10^DIGITS, as a natural consequence of discarding top bits; ovf=1 when the input was >= 10^DIGITS.
- Reset mid-conversion: abort immediately to the reset values above. No out_valid is produced for the aborted value.
- Value 0 converts to all-zero digits; no special case.

Optional Feature:
- Macro BCD_OVF_SAT_EN.
- Defined: when ovf=1, DONE loads every digit with 9 (9999) instead of the modulo result. ovf still =1.
- Undefined: modulo behaviour as described in Behaviour. The ovf flag exists in both builds.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Localparam BCD_W = DIGITS*4.
  - Constant function pow10(DIGITS), used for the ovf compare.
  - Counter width $clog2(BIN_W+1).
- One natural sub-module, bcd_digit_adj: combinational 4-bit "add 3 if >= 5". Instantiated DIGITS times in a generate loop inside the SHIFT datapath.

Test Plan:
- Reset, then bin_in=0 with in_valid for 1 cycle -> out_valid exactly 15 cycles later; digits 0,0,0,0; ovf=0.
- bin_in=1234 -> dig3..dig0 = 1,2,3,4; ovf=0; in_ready low for cycles 1..15 after accept.
- bin_in=9999, then 10000 held valid back-to-back:
  - First result 9,9,9,9 with ovf=0.
  - Second accepted the cycle after the first DONE; result 0,0,0,0 with ovf=1 without macro, 9,9,9,9 with BCD_OVF_SAT_EN.
- bin_in=12345 -> ovf=1; digits 2,3,4,5 without macro, 9,9,9,9 with macro.
- Accept 4321, pulse in_valid with 5678 at cycle 5 (busy) -> ignored; only 4,3,2,1 appears; in_ready returns 1 after DONE.
- Assert rst_n=0 at cycle 7 of converting 8765 -> digits 0, ovf 0 asynchronously, no out_valid. After release, convert 42 -> 0,0,4,2.
